temperature_avg_seq: RTL and testbench

Parametrised, sequential successor to the combinational temperature averaging path. On a `start_i` request it snapshots N sensor readings and their enable mask, then accumulates the enabled readings one per cycle. It divides the sum by the active-sensor count with a bit-serial restoring divider and rounds the result. It then drives the LED bar, the out-of-range alert and a one-cycle `valid_o` pulse. It sits between the raw sensor bus and the display/alert logic in the temperature subsystem.

---
 rtl/temperature_pkg.sv | 12 +
 rtl/temp_seq_divider.sv | 42 ++++
 rtl/temperature_avg_seq.sv | 114 +++++++++++
 tb/tb_temperature_avg_seq.sv | 125 ++++++++++++
 4 files changed

// File: rtl/temperature_pkg.sv
// temperature_pkg: shared FSM states, default thresholds and width helper for the temperature averaging blocks
package temperature_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, FINISH} temp_state_e;
  localparam int TEMP_T_LOW = 19;
  localparam int TEMP_T_HIGH = 26;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/temp_seq_divider.sv
// temp_seq_divider: bit-serial restoring divider, one quotient bit per cycle MSB first, fixed SUM_W-cycle latency
module temp_seq_divider
  import temperature_pkg::*;
#(
  parameter int SUM_W = 11,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [SUM_W-1:0] quotient,
  output logic [CNT_W-1:0] remainder
);
  localparam int IW = clog2(SUM_W + 1);
  logic [IW-1:0] iter;
  logic [CNT_W-1:0] dvs;
  logic [CNT_W:0] trial;
  logic fit;
  // quotient doubles as the dividend shift register; quotient bits enter at the LSB
  assign trial = {remainder, quotient[SUM_W-1]};
  assign fit = trial >= {1'b0, dvs};
  assign done = iter == IW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      iter      <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      iter      <= IW'(SUM_W);
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (iter != '0) begin
      iter      <= iter - IW'(1);
      remainder <= fit ? CNT_W'(trial - {1'b0, dvs}) : trial[CNT_W-1:0];
      quotient  <= {quotient[SUM_W-2:0], fit};
    end
endmodule

// File: rtl/temperature_avg_seq.sv
// temperature_avg_seq: snapshot N readings, accumulate enabled ones, divide serially and drive LED bar/alert.
// Define TEMP_HYST_EN for an alert with hysteresis (HYST parameter); otherwise the alert is memoryless.
module temperature_avg_seq
  import temperature_pkg::*;
#(
  parameter int N_SENSORS = 5,
  parameter int DATA_W    = 8,
  parameter int LED_W     = 8,
  parameter int LED_SHIFT = 2,
  parameter int T_LOW     = TEMP_T_LOW,
  parameter int T_HIGH    = TEMP_T_HIGH
`ifdef TEMP_HYST_EN
  , parameter int HYST    = 1
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [N_SENSORS*DATA_W-1:0] sensors_data_i,
  input  logic [N_SENSORS-1:0]        sensors_en_i,
  output logic                        busy_o,
  output logic                        valid_o,
  output logic [DATA_W-1:0]           avg_o,
  output logic [LED_W-1:0]            led_output_o,
  output logic                        alert_o,
  output logic                        no_sensor_o
);
  localparam int CNT_W = clog2(N_SENSORS + 1);
  localparam int SUM_W = DATA_W + CNT_W;
  temp_state_e state, state_nxt;
  logic [DATA_W-1:0] data_q [N_SENSORS];
  logic [N_SENSORS-1:0] en_q;
  logic [SUM_W-1:0] sum_q, sum_nxt, quo;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, idx, rem;
  logic last, div_start, div_done, rnd, out_rng, alert_nxt;
  logic [SUM_W:0] avg_full;
  logic [DATA_W-1:0] avg_nxt;
  logic [LED_W-1:0] led_nxt;
  assign busy_o    = state != IDLE;
  assign last      = idx == CNT_W'(N_SENSORS - 1);
  assign sum_nxt   = sum_q + (en_q[idx] ? SUM_W'(data_q[idx]) : '0);
  assign cnt_nxt   = cnt_q + CNT_W'(en_q[idx]);
  assign div_start = state == ACCUM && last && cnt_nxt != '0;
  temp_seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .start    (div_start),
    .dividend (sum_nxt),
    .divisor  (cnt_nxt),
    .done     (div_done),
    .quotient (quo),
    .remainder(rem)
  );
  // round half up: bump the quotient when the remainder is at least half the divisor
  assign rnd      = {rem, 1'b0} >= {1'b0, cnt_q};
  assign avg_full = {1'b0, quo} + (SUM_W + 1)'(rnd);
  assign avg_nxt  = cnt_q == '0 ? '0 : |avg_full[SUM_W:DATA_W] ? '1 : avg_full[DATA_W-1:0];
  for (genvar g = 0; g < LED_W; g++) begin : g_led
    assign led_nxt[g] = (32'(avg_nxt) >> LED_SHIFT) > 32'(g);
  end
  assign out_rng = int'(avg_nxt) < T_LOW || int'(avg_nxt) > T_HIGH || cnt_q == '0;
`ifdef TEMP_HYST_EN
  logic in_band;
  assign in_band   = int'(avg_nxt) >= T_LOW + HYST && int'(avg_nxt) <= T_HIGH - HYST;
  assign alert_nxt = out_rng | (alert_o & ~in_band);
`else
  assign alert_nxt = out_rng;
`endif
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_i ? ACCUM : IDLE;
      ACCUM:   state_nxt = !last ? ACCUM : cnt_nxt != '0 ? DIVIDE : FINISH;
      DIVIDE:  state_nxt = div_done ? FINISH : DIVIDE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int k = 0; k < N_SENSORS; k++) data_q[k] <= '0;
      en_q         <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      idx          <= '0;
      valid_o      <= 1'b0;
      avg_o        <= '0;
      led_output_o <= '0;
      alert_o      <= 1'b0;
      no_sensor_o  <= 1'b0;
    end else begin
      valid_o <= state == FINISH;
      if (state == IDLE && start_i) begin
        for (int k = 0; k < N_SENSORS; k++) data_q[k] <= sensors_data_i[k*DATA_W +: DATA_W];
        en_q  <= sensors_en_i;
        sum_q <= '0;
        cnt_q <= '0;
        idx   <= '0;
      end
      if (state == ACCUM) begin
        sum_q <= sum_nxt;
        cnt_q <= cnt_nxt;
        idx   <= idx + CNT_W'(1);
      end
      if (state == FINISH) begin
        avg_o        <= avg_nxt;
        led_output_o <= led_nxt;
        alert_o      <= alert_nxt;
        no_sensor_o  <= cnt_q == '0;
      end
    end
endmodule

// File: tb/tb_temperature_avg_seq.sv
// tb_temperature_avg_seq: directed and randomized runs checked against an arithmetic reference model
module tb_temperature_avg_seq;
  localparam int N = 5;
  localparam int DW = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0] en = '0;
  logic busy, valid, alert, no_sensor;
  logic [DW-1:0] avg;
  logic [7:0] led;
  int checks = 0, errors = 0, m_alert = 0;
  always #5 clk = ~clk;
  temperature_avg_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .sensors_data_i(data), .sensors_en_i(en),
    .busy_o(busy), .valid_o(valid), .avg_o(avg), .led_output_o(led), .alert_o(alert),
    .no_sensor_o(no_sensor)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input int d[N], input logic [N-1:0] e, input int tp_avg, input bit poke);
    int s, c, a, n, lat;
    s = 0;
    c = 0;
    for (int k = 0; k < N; k++) begin
      data[k*DW +: DW] = DW'(d[k]);
      if (e[k]) begin s += d[k]; c++; end
    end
    en = e;
    start = 1'b1;
    a = c == 0 ? 0 : (2 * s + c) / (2 * c);
    if (a > 255) a = 255;
    n = a >> 2;
    if (n > 8) n = 8;
    if (c == 0 || a < 19 || a > 26) m_alert = 1;
`ifdef TEMP_HYST_EN
    else if (a >= 20 && a <= 25) m_alert = 0;
`else
    else m_alert = 0;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    data = 40'({$urandom, $urandom});
    en = 5'($urandom);
    chk("busy_after_start", busy, 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = poke && lat == 3;
    end while (!valid && lat < 40);
    start = 1'b0;
    chk("latency", lat, c == 0 ? 6 : 17);
    chk("avg", avg, a);
    chk("led", led, (1 << n) - 1);
    chk("alert", alert, m_alert);
    chk("no_sensor", no_sensor, c == 0);
    chk("busy_at_valid", busy, 0);
    if (tp_avg >= 0) chk("plan_avg", avg, tp_avg);
  endtask
  initial begin
    int d[N];
    int nv;
    logic [DW-1:0] held;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_avg", avg, 0);
    chk("rst_led", led, 0);
    chk("rst_alert", alert, 0);
    chk("rst_nosens", no_sensor, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    d = '{20, 22, 24, 21, 23};  run(d, 5'b11111, 22, 1'b0);
    d = '{20, 21, 21, 90, 90};  run(d, 5'b00111, 21, 1'b0);
    d = '{30, 28, 0, 0, 0};     run(d, 5'b00011, 29, 1'b0);
    d = '{50, 50, 50, 50, 50};  run(d, 5'b00000, 0, 1'b0);
    d = '{27, 27, 27, 27, 27};  run(d, 5'b11111, 27, 1'b0);
    d = '{26, 26, 26, 26, 26};  run(d, 5'b11111, 26, 1'b0);
    d = '{25, 25, 25, 25, 25};  run(d, 5'b11111, 25, 1'b0);
    d = '{255, 255, 255, 255, 255}; run(d, 5'b11111, 255, 1'b0);
    d = '{0, 0, 0, 0, 0};       run(d, 5'b10101, 0, 1'b0);
    d = '{10, 20, 30, 40, 50};  run(d, 5'b11111, 30, 1'b1);
    held = avg;
    nv = 0;
    repeat (20) begin
      @(posedge clk); #1;
      nv += int'(valid);
    end
    chk("single_valid", nv, 0);
    chk("avg_held", avg, held);
    data = 40'({$urandom, $urandom});
    en = 5'b11111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    m_alert = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_avg", avg, 0);
    chk("mid_rst_led", led, 0);
    chk("mid_rst_valid", valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nv = 0;
    repeat (25) begin
      @(posedge clk); #1;
      nv += int'(valid);
    end
    chk("no_valid_after_rst", nv, 0);
    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < N; k++) d[k] = $urandom_range(0, 255);
      if (r % 3 == 0) for (int k = 0; k < N; k++) d[k] = $urandom_range(15, 32);
      run(d, 5'($urandom), -1, 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
